regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_wb_select.sv | 38 +++
 rtl/regfile_sb.sv | 132 +++++++++++++
 tb/tb_regfile_sb.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and per-register record for the scoreboarded register file
package regfile_pkg;

    localparam int RF_INDEX       = 5;
    localparam int RF_WIDTH       = 32;
    localparam int RF_TAG         = 4;
    localparam int RF_READ_PORTS  = 2;
    localparam int RF_WRITE_PORTS = 3;

    typedef struct packed {
        logic [RF_WIDTH-1:0] data;
        logic                busy;
        logic [RF_TAG-1:0]   tag;
    } rf_entry_t;

endpackage

// File: rtl/regfile_wb_select.sv
// rtl/regfile_wb_select.sv - highest-index-wins writeback match for one register address
module regfile_wb_select
    import regfile_pkg::*;
#(
    parameter int s_index         = RF_INDEX,
    parameter int s_width         = RF_WIDTH,
    parameter int s_tag           = RF_TAG,
    parameter int num_write_ports = RF_WRITE_PORTS
) (
    input  logic [s_index-1:0]                       addr,
    input  logic [s_tag-1:0]                         ref_tag,
    input  logic [num_write_ports-1:0]               wb_valid,
    input  logic [num_write_ports-1:0][s_index-1:0]  wb_dest,
    input  logic [num_write_ports-1:0][s_tag-1:0]    wb_tag,
    input  logic [num_write_ports-1:0][s_width-1:0]  wb_data,
    output logic                                     hit,
    output logic [s_width-1:0]                       data,
    output logic                                     tag_hit
);

    // Ascending scan: a later port overwrites data, so the highest index wins.
    // tag_hit is an OR over every matching port, not just the winner.
    always_comb begin
        hit     = 1'b0;
        data    = '0;
        tag_hit = 1'b0;
        for (int p = 0; p < num_write_ports; p++) begin
            if (wb_valid[p] && wb_dest[p] == addr) begin
                hit  = 1'b1;
                data = wb_data[p];
                if (wb_tag[p] == ref_tag) begin
                    tag_hit = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with busy/tag scoreboard and same-cycle bypass
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int s_index         = RF_INDEX,
    parameter int s_width         = RF_WIDTH,
    parameter int s_tag           = RF_TAG,
    parameter int num_read_ports  = RF_READ_PORTS,
    parameter int num_write_ports = RF_WRITE_PORTS
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     flush,
    input  logic                                     alloc_valid,
    input  logic [s_index-1:0]                       alloc_dest,
    input  logic [s_tag-1:0]                         alloc_tag,
    input  logic [num_write_ports-1:0]               wb_valid,
    input  logic [num_write_ports-1:0][s_index-1:0]  wb_dest,
    input  logic [num_write_ports-1:0][s_tag-1:0]    wb_tag,
    input  logic [num_write_ports-1:0][s_width-1:0]  wb_data,
    input  logic [num_read_ports-1:0][s_index-1:0]   rd_src,
    output logic [num_read_ports-1:0][s_width-1:0]   rd_data,
    output logic [num_read_ports-1:0]                rd_busy,
    output logic [num_read_ports-1:0][s_tag-1:0]     rd_tag
);

    localparam int NREG = 2**s_index;

    rf_entry_t          regs_q      [NREG];
    rf_entry_t          regs_d      [NREG];
    logic               reg_hit     [NREG];
    logic [s_width-1:0] reg_wb_data [NREG];
    logic               reg_tag_hit [NREG];

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        localparam logic [s_index-1:0] ADDR = s_index'(i);
        regfile_wb_select #(
            .s_index         (s_index),
            .s_width         (s_width),
            .s_tag           (s_tag),
            .num_write_ports (num_write_ports)
        ) u_sel (
            .addr     (ADDR),
            .ref_tag  (regs_q[i].tag),
            .wb_valid (wb_valid),
            .wb_dest  (wb_dest),
            .wb_tag   (wb_tag),
            .wb_data  (wb_data),
            .hit      (reg_hit[i]),
            .data     (reg_wb_data[i]),
            .tag_hit  (reg_tag_hit[i])
        );
    end

    // Priority on busy/tag: flush > allocation > tag-matched writeback.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (i == 0) begin
                regs_d[i] = '0;
            end else begin
                if (reg_hit[i]) begin
                    regs_d[i].data = reg_wb_data[i];
                end
                if (flush) begin
                    regs_d[i].busy = 1'b0;
                end else if (alloc_valid && alloc_dest == s_index'(i)) begin
                    regs_d[i].busy = 1'b1;
                    regs_d[i].tag  = alloc_tag;
                end else if (regs_q[i].busy && reg_tag_hit[i]) begin
                    regs_d[i].busy = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar r = 0; r < num_read_ports; r++) begin : g_rd
        rf_entry_t          ent;
        logic               byp_hit;
        logic [s_width-1:0] byp_data;
        logic               byp_tag_hit;
        logic [s_width-1:0] port_data;
        logic               port_busy;
        logic [s_tag-1:0]   port_tag;

        assign ent = regs_q[rd_src[r]];

        regfile_wb_select #(
            .s_index         (s_index),
            .s_width         (s_width),
            .s_tag           (s_tag),
            .num_write_ports (num_write_ports)
        ) u_sel (
            .addr     (rd_src[r]),
            .ref_tag  (ent.tag),
            .wb_valid (wb_valid),
            .wb_dest  (wb_dest),
            .wb_tag   (wb_tag),
            .wb_data  (wb_data),
            .hit      (byp_hit),
            .data     (byp_data),
            .tag_hit  (byp_tag_hit)
        );

        // Gating on rst_n keeps bypass inputs from leaking out during reset.
        always_comb begin
            port_data = '0;
            port_busy = 1'b0;
            port_tag  = '0;
            if (rst_n && rd_src[r] != '0) begin
                port_data = byp_hit ? byp_data : ent.data;
                port_busy = ent.busy && !byp_tag_hit;
                port_tag  = ent.tag;
            end
        end

        assign rd_data[r] = port_data;
        assign rd_busy[r] = port_busy;
        assign rd_tag[r]  = port_tag;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard bench for regfile_sb with directed vectors
module tb_regfile_sb;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  flush;
    logic                  alloc_valid;
    logic [4:0]            alloc_dest;
    logic [3:0]            alloc_tag;
    logic [2:0]            wb_valid;
    logic [2:0][4:0]       wb_dest;
    logic [2:0][3:0]       wb_tag;
    logic [2:0][31:0]      wb_data;
    logic [1:0][4:0]       rd_src;
    logic [1:0][31:0]      rd_data;
    logic [1:0]            rd_busy;
    logic [1:0][3:0]       rd_tag;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        busy;
        logic [3:0]  tag;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    regfile_sb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .alloc_valid (alloc_valid),
        .alloc_dest  (alloc_dest),
        .alloc_tag   (alloc_tag),
        .wb_valid    (wb_valid),
        .wb_dest     (wb_dest),
        .wb_tag      (wb_tag),
        .wb_data     (wb_data),
        .rd_src      (rd_src),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .rd_tag      (rd_tag)
    );

    always #5 clk = ~clk;

    // Monitor: drain every expectation queued for this cycle on the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (rd_data[e.port] !== e.data || rd_busy[e.port] !== e.busy ||
                (e.busy && rd_tag[e.port] !== e.tag)) begin
                bad++;
                $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, want data=%h busy=%b tag=%h",
                         e.name, e.port, rd_data[e.port], rd_busy[e.port], rd_tag[e.port],
                         e.data, e.busy, e.tag);
            end
        end
    end

    task automatic expect_rd(input int port, input logic [31:0] d, input logic b,
                             input logic [3:0] t, input string nm);
        exp_t e;
        e.port = port;
        e.data = d;
        e.busy = b;
        e.tag  = t;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic clear_inputs();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        alloc_dest  = '0;
        alloc_tag   = '0;
        wb_valid    = '0;
        wb_dest     = '0;
        wb_tag      = '0;
        wb_data     = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic wb(input int p, input logic [4:0] d, input logic [3:0] t, input logic [31:0] v);
        wb_valid[p] = 1'b1;
        wb_dest[p]  = d;
        wb_tag[p]   = t;
        wb_data[p]  = v;
    endtask

    task automatic alloc(input logic [4:0] d, input logic [3:0] t);
        alloc_valid = 1'b1;
        alloc_dest  = d;
        alloc_tag   = t;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        rd_src = '0;
        #1;
        wb(0, 5'd5, 4'd0, 32'hDEAD);
        rd_src[0] = 5'd5;
        rd_src[1] = 5'd0;
        expect_rd(0, 32'h0, 1'b0, 4'h0, "reset_bypass_blocked");
        expect_rd(1, 32'h0, 1'b0, 4'h0, "reset_r0");
        @(posedge clk);
        #1;
        clear_inputs();
        rst_n = 1'b1;
        expect_rd(0, 32'h0, 1'b0, 4'h0, "reset_wb_discarded");

        // Tag-matched writeback clears busy and bypasses data.
        step(); alloc(5'd5, 4'd3); rd_src[0] = 5'd5; rd_src[1] = 5'd5;
        expect_rd(0, 32'h0, 1'b0, 4'h0, "alloc_not_visible");
        step();
        expect_rd(0, 32'h0, 1'b1, 4'h3, "r5_busy_tag3");
        step(); wb(0, 5'd5, 4'd3, 32'hAA);
        expect_rd(0, 32'hAA, 1'b0, 4'h3, "r5_bypass_p0");
        expect_rd(1, 32'hAA, 1'b0, 4'h3, "r5_bypass_p1");
        step();
        expect_rd(0, 32'hAA, 1'b0, 4'h3, "r5_stored");

        // Stale producer writes data but leaves busy/tag.
        step(); alloc(5'd7, 4'd2); rd_src[0] = 5'd7; rd_src[1] = 5'd5;
        step(); wb(1, 5'd7, 4'd1, 32'h11);
        expect_rd(0, 32'h11, 1'b1, 4'h2, "r7_stale_bypass");
        step();
        expect_rd(0, 32'h11, 1'b1, 4'h2, "r7_stale_stored");

        // Three writebacks to one register: port 2 wins.
        step(); wb(0, 5'd4, 4'd0, 32'h1); wb(1, 5'd4, 4'd0, 32'h2); wb(2, 5'd4, 4'd0, 32'h3);
        rd_src[0] = 5'd4; rd_src[1] = 5'd4;
        expect_rd(0, 32'h3, 1'b0, 4'h0, "r4_multi_bypass");
        step();
        expect_rd(1, 32'h3, 1'b0, 4'h0, "r4_multi_stored");

        // Allocation beats a tag-matched writeback in the same cycle.
        step(); alloc(5'd9, 4'd6); rd_src[0] = 5'd9; rd_src[1] = 5'd9;
        step(); alloc(5'd9, 4'd6); wb(0, 5'd9, 4'd6, 32'h99);
        expect_rd(0, 32'h99, 1'b0, 4'h6, "r9_alloc_wb_bypass");
        step();
        expect_rd(0, 32'h99, 1'b1, 4'h6, "r9_alloc_wins");
        step(); alloc(5'd9, 4'd7); wb(2, 5'd9, 4'd6, 32'h9A);
        step();
        expect_rd(1, 32'h9A, 1'b1, 4'h7, "r9_retag");

        // Flush overrides same-cycle allocation; writeback data still lands.
        step(); alloc(5'd3, 4'd1);
        step(); alloc(5'd8, 4'd2); rd_src[0] = 5'd3; rd_src[1] = 5'd8;
        expect_rd(0, 32'h0, 1'b1, 4'h1, "r3_busy");
        step(); flush = 1'b1; alloc(5'd3, 4'd5); wb(0, 5'd8, 4'd0, 32'h88);
        expect_rd(0, 32'h0, 1'b1, 4'h1, "flush_not_visible");
        step();
        expect_rd(0, 32'h0, 1'b0, 4'h0, "r3_flushed");
        expect_rd(1, 32'h88, 1'b0, 4'h0, "r8_flushed_data");
        step(); rd_src[0] = 5'd7; rd_src[1] = 5'd9;
        expect_rd(0, 32'h11, 1'b0, 4'h0, "r7_flushed");
        expect_rd(1, 32'h9A, 1'b0, 4'h0, "r9_flushed");

        // Register 0 is constant.
        step(); wb(2, 5'd0, 4'd0, 32'hFF); alloc(5'd0, 4'd3); rd_src[0] = 5'd0;
        expect_rd(0, 32'h0, 1'b0, 4'h0, "r0_bypass");
        step();
        expect_rd(0, 32'h0, 1'b0, 4'h0, "r0_stored");

        // Mid-sequence reset with bypass inputs active.
        step(); alloc(5'd6, 4'd4); rd_src[0] = 5'd4; rd_src[1] = 5'd7;
        expect_rd(0, 32'h3, 1'b0, 4'h0, "r4_pre_reset");
        step(); wb(0, 5'd4, 4'd0, 32'h55); wb(1, 5'd7, 4'd0, 32'h77);
        rst_n = 1'b0;
        expect_rd(0, 32'h0, 1'b0, 4'h0, "reset_async_p0");
        expect_rd(1, 32'h0, 1'b0, 4'h0, "reset_async_p1");
        @(posedge clk);
        #1;
        clear_inputs();
        rst_n = 1'b1;
        expect_rd(0, 32'h0, 1'b0, 4'h0, "post_reset_r4");
        expect_rd(1, 32'h0, 1'b0, 4'h0, "post_reset_r7");
        step(); rd_src[0] = 5'd6; rd_src[1] = 5'd9;
        expect_rd(0, 32'h0, 1'b0, 4'h0, "post_reset_r6");
        expect_rd(1, 32'h0, 1'b0, 4'h0, "post_reset_r9");

        step();
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
